// File: rtl/add_seq_ctrl_pkg.sv
// Shared state encodings and index-width helper for the multi-precision add sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package add_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index needs at least one bit, even when there is only one chunk.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_add.sv
// WIDTH-bit Add datapath: z = a + b + cin (mod 2^WIDTH), carry-out on cout[0].
// Latency: combinational.
// Backpressure: none.
module add_seq_ctrl_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] z,
  output logic [0:0]       cout
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {1'b0, cin};
  assign z        = full_sum[WIDTH-1:0];
  assign cout     = full_sum[WIDTH];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision adder: WIDTH*CHUNKS-bit sum through one WIDTH-bit adder, LSB chunk first.
// Latency: start at T -> busy T+1..T+CHUNKS -> done pulse at T+CHUNKS+1.
// Backpressure: start is ignored (not queued) while busy; accepted in IDLE or DONE.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    start,
  input  logic [WIDTH*CHUNKS-1:0] a,
  input  logic [WIDTH*CHUNKS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*CHUNKS-1:0] sum,
  output logic                    cout
);

  localparam int TOTAL = WIDTH * CHUNKS;
  localparam int IDX_W = idx_width(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [TOTAL-1:0] op_a, op_b, acc, acc_nxt;
  logic             carry;
  logic             accept, last;
  logic [WIDTH-1:0] add_a, add_b, add_z;
  logic [0:0]       add_cout;

  assign last  = (idx == LAST_IDX);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign add_a = op_a[idx*WIDTH +: WIDTH];
  assign add_b = op_b[idx*WIDTH +: WIDTH];

  add_seq_ctrl_add #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (WIDTH'(carry)),
    .z    (add_z),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    acc_nxt   = acc;
    acc_nxt[idx*WIDTH +: WIDTH] = add_z;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a  <= a;
        op_b  <= b;
        carry <= cin;
        idx   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        carry <= add_cout[0];
        // Publish the merged final chunk so sum never shows a partial result.
        if (last) begin
          idx  <= '0;
          sum  <= acc_nxt;
          cout <= add_cout[0];
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WIDTH=8, CHUNKS=4): vector table, random ops, corner sequences.
module tb_add_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int CHUNKS = 4;
  localparam int TOTAL  = WIDTH * CHUNKS;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             start;
  logic [TOTAL-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [TOTAL-1:0] sum;
  logic             cout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [TOTAL-1:0] s;
    logic             co;
  } exp_t;

  typedef struct {
    logic [TOTAL-1:0] a;
    logic [TOTAL-1:0] b;
    logic             cin;
    logic [TOTAL-1:0] s;
    logic             co;
  } vec_t;

  exp_t             sb_q[$];
  vec_t             vecs[6];
  logic [TOTAL-1:0] last_sum = '0;

  add_seq_ctrl #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Rst && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_sum", sum, e.s);
        chk("sb_cout", cout, e.co);
      end
    end
  end

  // One start pulse, then cycle-exact busy/done/hold checks through the done pulse.
  task automatic do_op(input logic [TOTAL-1:0] ta, input logic [TOTAL-1:0] tb_v,
                       input logic tc, input logic [TOTAL-1:0] es, input logic eco);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    sb_q.push_back('{es, eco});
    tick();
    start = 1'b0;
    for (int k = 0; k < CHUNKS; k++) begin
      chk("run_busy", busy, 1'b1);
      chk("run_done_low", done, 1'b0);
      chk("run_sum_hold", sum, last_sum);
      tick();
    end
    chk("done_pulse", done, 1'b1);
    chk("done_busy_low", busy, 1'b0);
    chk("done_sum", sum, es);
    chk("done_cout", cout, eco);
    last_sum = es;
    tick();
    chk("done_width", done, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

    Rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    Rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);
    end

    for (int i = 0; i < 6; i++) begin
      logic [TOTAL-1:0] ra, rb;
      logic             rc;
      logic [TOTAL:0]   ref_sum;
      ra = TOTAL'($urandom);
      rb = TOTAL'($urandom);
      rc = 1'($urandom_range(1, 0));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{TOTAL{1'b0}}, rc};
      do_op(ra, rb, rc, ref_sum[TOTAL-1:0], ref_sum[TOTAL]);
    end

    // Result holds while idle.
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("hold_sum", sum, 32'h2345_6789);
      chk("hold_done", done, 1'b0);
      tick();
    end

    // start and operand changes during RUN are ignored.
    a = 32'h1; b = 32'h2; cin = 1'b0; start = 1'b1;
    sb_q.push_back('{32'h3, 1'b0});
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; a = 32'h1;
    tick();
    chk("ign_done_early", done, 1'b0);
    tick();
    chk("ign_done", done, 1'b1);
    chk("ign_sum", sum, 32'h3);
    last_sum = 32'h3;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ign_no_rerun", done, 1'b0);
      chk("ign_idle", busy, 1'b0);
    end

    // Reset mid-run aborts with no done pulse.
    a = 32'h55; b = 32'h66; cin = 1'b0; start = 1'b1;
    sb_q.push_back('{32'hBB, 1'b0});
    tick();
    start = 1'b0;
    tick();
    Rst = 1'b1;
    sb_q.delete();
    tick();
    Rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sum", sum, '0);
    chk("abort_cout", cout, 1'b0);
    last_sum = '0;
    for (int k = 0; k < 5; k++) begin
      chk("abort_no_done", done, 1'b0);
      tick();
    end
    do_op(32'd5, 32'd7, 1'b0, 32'd12, 1'b0);

    // Back-to-back: start held high, new operands presented in the DONE cycle.
    a = 32'h10; b = 32'h20; cin = 1'b0; start = 1'b1;
    sb_q.push_back('{32'h30, 1'b0});
    for (int k = 0; k < CHUNKS + 1; k++) tick();
    chk("b2b_done1", done, 1'b1);
    chk("b2b_sum1", sum, 32'h30);
    a = 32'h1; b = 32'h1;
    sb_q.push_back('{32'h2, 1'b0});
    tick();
    start = 1'b0;
    for (int k = 0; k < CHUNKS; k++) begin
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_sum_hold", sum, 32'h30);
      tick();
    end
    chk("b2b_done2", done, 1'b1);
    chk("b2b_sum2", sum, 32'h2);
    tick();
    chk("b2b_idle", busy, 1'b0);
    chk("b2b_done_end", done, 1'b0);

    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
